// File: rtl/uart_rx_hex_parser.sv
// uart_rx_hex_parser
// Pops ASCII characters from a show-ahead RX FIFO and assembles pairs of hex
// digits into bytes. A lone digit followed by a terminator emits {4'h0, digit}.
// Illegal characters, receiver errors and an idle timeout on a half-entered
// pair raise a one-cycle parse_error pulse.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   rx_data        FIFO head character (valid when fifo_empty = 0)
//   fifo_empty     FIFO empty flag
//   rx_error       receiver error flag for the head character
//   rx_read        pop strobe, one cycle per character
//   byte_out       last assembled byte (held until the next emit)
//   byte_valid     one-cycle pulse while a new byte_out is presented
//   parse_error    one-cycle pulse on illegal char, rx error or timeout
//   byte_count     bytes emitted, wraps 255 -> 0
//   state          FSM state (0 idle, 1 decode, 2 emit)
module uart_rx_hex_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  TERM_CHAR      = 8'h0D
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       fifo_empty,
  input  logic       rx_error,
  output logic       rx_read,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       parse_error,
  output logic [7:0] byte_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StEmit   = 2'd2
  } state_e;

  localparam int unsigned TmoW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TmoLastInt = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TmoLastInt);

  state_e          state_q, state_d;
  logic [7:0]      char_q, char_d;
  logic            err_q, err_d;
  logic [7:0]      acc_q, acc_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic [7:0]      byte_count_q, byte_count_d;
  logic            perr_q, perr_d;

  logic       is_dec, is_upper, is_lower, is_hex, is_term;
  logic [3:0] nibble;

  always_comb begin
    is_dec   = (char_q >= 8'h30) && (char_q <= 8'h39);
    is_upper = (char_q >= 8'h41) && (char_q <= 8'h46);
    is_lower = (char_q >= 8'h61) && (char_q <= 8'h66);
    is_hex   = is_dec || is_upper || is_lower;
    is_term  = (char_q == 8'h20) || (char_q == 8'h0A) || (char_q == TERM_CHAR);
    // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
    nibble   = is_dec ? char_q[3:0] : char_q[3:0] + 4'd9;
  end

  always_comb begin
    state_d      = state_q;
    char_d       = char_q;
    err_d        = err_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    byte_out_d   = byte_out_q;
    byte_count_d = byte_count_q;
    perr_d       = 1'b0;
    rx_read      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          // A pop always wins over a timeout in the same cycle
          rx_read = 1'b1;
          char_d  = rx_data;
          err_d   = rx_error;
          tmo_d   = '0;
          state_d = StDecode;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == 2'd1)) begin
          if (tmo_q == TmoLast) begin
            perr_d = 1'b1;
            cnt_d  = 2'd0;
            acc_d  = 8'h00;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          tmo_d = '0;
        end
      end

      StDecode: begin
        tmo_d   = '0;
        state_d = StIdle;
        if (err_q) begin
          perr_d = 1'b1;
          acc_d  = 8'h00;
          cnt_d  = 2'd0;
        end else if (is_hex) begin
          acc_d = {acc_q[3:0], nibble};
          if (cnt_q == 2'd1) begin
            // Load the byte on entry to emit so it is valid alongside byte_valid
            cnt_d        = 2'd2;
            byte_out_d   = {acc_q[3:0], nibble};
            byte_count_d = byte_count_q + 8'd1;
            state_d      = StEmit;
          end else begin
            cnt_d = 2'd1;
          end
        end else if (is_term) begin
          if (cnt_q == 2'd1) begin
            byte_out_d   = {4'h0, acc_q[3:0]};
            byte_count_d = byte_count_q + 8'd1;
            state_d      = StEmit;
          end
        end else begin
          perr_d = 1'b1;
          acc_d  = 8'h00;
          cnt_d  = 2'd0;
        end
      end

      StEmit: begin
        cnt_d   = 2'd0;
        acc_d   = 8'h00;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      char_q       <= 8'h00;
      err_q        <= 1'b0;
      acc_q        <= 8'h00;
      cnt_q        <= 2'd0;
      tmo_q        <= '0;
      byte_out_q   <= 8'h00;
      byte_count_q <= 8'h00;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      char_q       <= char_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      byte_out_q   <= byte_out_d;
      byte_count_q <= byte_count_d;
      perr_q       <= perr_d;
    end
  end

  assign byte_out    = byte_out_q;
  assign byte_valid  = (state_q == StEmit);
  assign parse_error = perr_q;
  assign byte_count  = byte_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_uart_rx_hex_parser.sv
module tb_uart_rx_hex_parser;

  logic       clk;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       fifo_empty;
  logic       rx_error;
  logic       rx_read;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       parse_error;
  logic [7:0] byte_count;
  logic [1:0] state;

  uart_rx_hex_parser #(
    .TIMEOUT_CYCLES(20),
    .TERM_CHAR     (8'h0D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .fifo_empty (fifo_empty),
    .rx_error   (rx_error),
    .rx_read    (rx_read),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .parse_error(parse_error),
    .byte_count (byte_count),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model feeding the DUT
  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } ent_t;
  ent_t q[$];

  initial begin
    logic p;
    forever begin
      @(negedge clk);
      p = rx_read;
      @(posedge clk);
      #1;
      if (p && q.size() > 0) void'(q.pop_front());
      if (q.size() > 0) begin
        rx_data    = q[0].d;
        rx_error   = q[0].e;
        fifo_empty = 1'b0;
      end else begin
        rx_data    = 8'h00;
        rx_error   = 1'b0;
        fifo_empty = 1'b1;
      end
    end
  end

  // Output monitor
  int cyc = 0, pops = 0, errs = 0, last_pop_cyc = 0, last_err_cyc = 0;
  logic [7:0] got[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rx_read) begin
        pops++;
        last_pop_cyc = cyc;
        chk("rx_read_while_empty", {31'd0, fifo_empty}, 32'd0);
      end
      if (byte_valid) begin
        got.push_back(byte_out);
        chk("valid_with_parse_error", {31'd0, parse_error}, 32'd0);
      end
      if (parse_error) begin
        errs++;
        last_err_cyc = cyc;
      end
    end
  end

  // Reference model: spec rules applied to a whole character burst
  logic [7:0] m_d[$];
  logic       m_e[$];

  function automatic int hexval(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
    return -1;
  endfunction

  task automatic model_run(output logic [7:0] exp_b[$], output int exp_e);
    int pend = -1;
    int v;
    exp_b = {};
    exp_e = 0;
    foreach (m_d[i]) begin
      v = hexval(m_d[i]);
      if (m_e[i]) begin
        exp_e++;
        pend = -1;
      end else if (v >= 0) begin
        if (pend < 0) pend = v;
        else begin
          exp_b.push_back(8'(pend * 16 + v));
          pend = -1;
        end
      end else if (m_d[i] == 8'h20 || m_d[i] == 8'h0A || m_d[i] == 8'h0D) begin
        if (pend >= 0) exp_b.push_back(8'(pend));
        pend = -1;
      end else begin
        exp_e++;
        pend = -1;
      end
    end
    // A leftover digit times out during the idle gap after the burst
    if (pend >= 0) exp_e++;
  endtask

  task automatic push_char(input logic [7:0] c, input logic e);
    q.push_back('{d: c, e: e});
    m_d.push_back(c);
    m_e.push_back(e);
  endtask

  task automatic settle();
    int n = 0;
    while (q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("settle_timeout", 32'd1, 32'd0);
    repeat (40) @(negedge clk);
  endtask

  int pre_pops, pre_errs;

  task automatic apply(input string s, input int err_idx);
    pre_pops = pops;
    pre_errs = errs;
    got.delete();
    m_d.delete();
    m_e.delete();
    for (int i = 0; i < s.len(); i++) push_char(s[i], (i == err_idx));
    settle();
  endtask

  typedef struct {
    string      text;
    int         err_idx;
    int         n_bytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         n_err;
  } vec_t;

  vec_t vecs[10];
  int   exp_count = 0;

  initial begin
    logic [7:0] exp_b[$];
    int         exp_e;
    int         need;
    int         n;

    vecs[0] = '{"4F\015", -1, 1, 8'h4F, 8'h00, 0};
    vecs[1] = '{"a 7b",   -1, 2, 8'h0A, 8'h7B, 0};
    vecs[2] = '{"G123",   -1, 1, 8'h12, 8'h00, 2};
    vecs[3] = '{"566",     0, 1, 8'h66, 8'h00, 1};
    vecs[4] = '{"9",      -1, 0, 8'h00, 8'h00, 1};
    vecs[5] = '{"00",     -1, 1, 8'h00, 8'h00, 0};
    vecs[6] = '{"fF\n",   -1, 1, 8'hFF, 8'h00, 0};
    vecs[7] = '{"3\015",  -1, 1, 8'h03, 8'h00, 0};
    vecs[8] = '{"Zx",     -1, 0, 8'h00, 8'h00, 2};
    vecs[9] = '{"\n \015", -1, 0, 8'h00, 8'h00, 0};

    reset_n    = 1'b0;
    rx_data    = 8'h00;
    fifo_empty = 1'b1;
    rx_error   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_read", {31'd0, rx_read}, 32'd0);
    chk("reset_byte_out", {24'd0, byte_out}, 32'd0);
    chk("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("reset_parse_error", {31'd0, parse_error}, 32'd0);
    chk("reset_byte_count", {24'd0, byte_count}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors
    foreach (vecs[i]) begin
      apply(vecs[i].text, vecs[i].err_idx);
      chk($sformatf("v%0d_pops", i), 32'(pops - pre_pops), 32'(vecs[i].text.len()));
      chk($sformatf("v%0d_nbytes", i), 32'(got.size()), 32'(vecs[i].n_bytes));
      if (got.size() > 0 && vecs[i].n_bytes > 0)
        chk($sformatf("v%0d_byte0", i), {24'd0, got[0]}, {24'd0, vecs[i].b0});
      if (got.size() > 1 && vecs[i].n_bytes > 1)
        chk($sformatf("v%0d_byte1", i), {24'd0, got[1]}, {24'd0, vecs[i].b1});
      chk($sformatf("v%0d_errors", i), 32'(errs - pre_errs), 32'(vecs[i].n_err));
      exp_count = (exp_count + vecs[i].n_bytes) % 256;
      chk($sformatf("v%0d_byte_count", i), {24'd0, byte_count}, 32'(exp_count));
    end

    // Timeout latency: pop of '9' in cycle N, 20 idle cycles, pulse just after
    pre_errs = errs;
    m_d.delete();
    m_e.delete();
    push_char(8'h39, 1'b0);
    n = 0;
    while (errs == pre_errs && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", {31'd0, (errs != pre_errs)}, 32'd1);
    chk("timeout_latency_window",
        {31'd0, ((last_err_cyc - last_pop_cyc) >= 21) && ((last_err_cyc - last_pop_cyc) <= 23)},
        32'd1);
    repeat (10) @(negedge clk);

    // Randomized bursts against the model
    for (int b = 0; b < 30; b++) begin
      pre_errs = errs;
      got.delete();
      m_d.delete();
      m_e.delete();
      for (int k = 0; k < int'($urandom_range(1, 16)); k++) begin
        int r;
        string hexs = "0123456789abcdefABCDEF";
        string bads = "GzQ!-.";
        logic [7:0] c;
        r = int'($urandom_range(0, 99));
        if (r < 60) c = hexs[int'($urandom_range(0, 21))];
        else if (r < 80) begin
          case ($urandom_range(0, 2))
            0: c = 8'h20;
            1: c = 8'h0A;
            default: c = 8'h0D;
          endcase
        end else c = bads[int'($urandom_range(0, 5))];
        push_char(c, ($urandom_range(0, 19) == 0));
      end
      settle();
      model_run(exp_b, exp_e);
      chk($sformatf("rnd%0d_nbytes", b), 32'(got.size()), 32'(exp_b.size()));
      for (int k = 0; k < exp_b.size() && k < got.size(); k++)
        chk($sformatf("rnd%0d_byte%0d", b, k), {24'd0, got[k]}, {24'd0, exp_b[k]});
      chk($sformatf("rnd%0d_errors", b), 32'(errs - pre_errs), 32'(exp_e));
      exp_count = (exp_count + exp_b.size()) % 256;
      chk($sformatf("rnd%0d_byte_count", b), {24'd0, byte_count}, 32'(exp_count));
    end

    // byte_count wrap
    need = (255 - exp_count) % 256;
    pre_errs = errs;
    got.delete();
    for (int k = 0; k < need; k++) begin
      q.push_back('{d: 8'h61, e: 1'b0});
      q.push_back('{d: 8'h61, e: 1'b0});
    end
    settle();
    chk("wrap_count_255", {24'd0, byte_count}, 32'd255);
    apply("aa", -1);
    chk("wrap_count_0", {24'd0, byte_count}, 32'd0);
    chk("wrap_byte", {24'd0, byte_out}, 32'hAA);
    chk("wrap_errors", 32'(errs - pre_errs), 32'd0);
    apply("12", -1);
    exp_count = 1;
    chk("pre_reset_count", {24'd0, byte_count}, 32'(exp_count));

    // Reset between the digits of a pair
    got.delete();
    push_char(8'h37, 1'b0);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset_rx_read", {31'd0, rx_read}, 32'd0);
    chk("midreset_byte_out", {24'd0, byte_out}, 32'd0);
    chk("midreset_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("midreset_parse_error", {31'd0, parse_error}, 32'd0);
    chk("midreset_byte_count", {24'd0, byte_count}, 32'd0);
    chk("midreset_state", {30'd0, state}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    pre_errs = errs;
    apply("34", -1);
    chk("postreset_nbytes", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("postreset_byte", {24'd0, got[0]}, 32'h34);
    chk("postreset_errors", 32'(errs - pre_errs), 32'd0);
    chk("postreset_count", {24'd0, byte_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
